// File: rtl/mem_responder.sv
// Word-addressed RAM target with strobe/ack handshake and programmable access latency.
// Define MEMRESP_WP_EN to reject writes to the first WP_WORDS words of the window.
module mem_responder #(
  parameter logic [31:0] BASE      = 32'h0000_1000,
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned WP_WORDS  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        strb,
  input  logic        rw,
  input  logic [31:0] addr,
  inout  wire  [31:0] data,
  output logic        ack,
  output logic        err
);

  localparam int unsigned Depth = 1 << ADDR_BITS;
`ifdef MEMRESP_WP_EN
  localparam bit WpEnable = 1'b1;
`else
  localparam bit WpEnable = 1'b0;
`endif

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
      $error("mem_responder: LATENCY must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e               state_q;
  logic [3:0]           cnt_q;
  logic [31:0]          addr_q, wdata_q, rdata_q;
  logic                 rw_q, drive_q, wr_en_q;
  logic [ADDR_BITS-1:0] wr_idx_q;
  logic [31:0]          ram [Depth];

  logic [31:0]          cur_addr, off;
  logic                 cur_rw, in_win, wp_hit, reject, enter_resp;
  logic [ADDR_BITS-1:0] cur_idx;

  // With LATENCY=1 the request goes IDLE->RESP in one edge, so decode the live inputs there.
  assign cur_addr = (state_q == StIdle) ? addr : addr_q;
  assign cur_rw   = (state_q == StIdle) ? rw : rw_q;
  assign off      = cur_addr - BASE;
  assign in_win   = {1'b0, off} < (33'd1 << ADDR_BITS);
  assign cur_idx  = off[ADDR_BITS-1:0];
  assign wp_hit   = WpEnable && cur_rw && (off < WP_WORDS);
  assign reject   = !in_win || wp_hit;

  assign enter_resp = ((state_q == StIdle) && strb && (LATENCY == 1)) ||
                      ((state_q == StWait) && (cnt_q == 4'd1));

  assign data = drive_q ? rdata_q : 'z;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      ack     <= 1'b0;
      err     <= 1'b0;
      drive_q <= 1'b0;
      wr_en_q <= 1'b0;
    end else begin
      ack     <= 1'b0;
      err     <= 1'b0;
      drive_q <= 1'b0;
      wr_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (strb) begin
            addr_q  <= addr;
            rw_q    <= rw;
            wdata_q <= data;
            cnt_q   <= 4'(LATENCY - 1);
            state_q <= StWait;
          end
        end
        StWait:  cnt_q <= cnt_q - 4'd1;
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      if (enter_resp) begin
        state_q  <= StResp;
        ack      <= 1'b1;
        err      <= reject;
        drive_q  <= !cur_rw && !reject;
        wr_en_q  <= cur_rw && !reject;
        wr_idx_q <= cur_idx;
      end
    end
  end

  // Write commits on the RESP->IDLE edge; reset in that cycle discards it.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp) rdata_q <= ram[cur_idx];
    if (!reset && (state_q == StResp) && wr_en_q) ram[wr_idx_q] <= wdata_q;
  end

endmodule
